// File: rtl/tlb_fa_unit_pkg.sv
// Shared constants and command encodings for the fully associative TLB.
package tlb_fa_unit_pkg;

    localparam int WORD_LENGTH       = 32;
    localparam int TLB_PAGE_BITS_DEF = 12;

    typedef enum logic [1:0] {
        TLB_CMD_NONE      = 2'b00,
        TLB_CMD_INSERT    = 2'b01,
        TLB_CMD_PURGE     = 2'b10,
        TLB_CMD_PURGE_ALL = 2'b11
    } tlbCmdT;

endpackage

// File: rtl/tlb_fa_unit_if.sv
// Lookup and command bus of the TLB; the master side issues requests,
// the slave side (the TLB) answers them.
interface tlb_fa_unit_if
    import tlb_fa_unit_pkg::*;
#(
    parameter int PAGE_BITS = TLB_PAGE_BITS_DEF,
    parameter int ACC_WIDTH = 8
);
    logic                             lkReq;
    logic [WORD_LENGTH-1:0]           lkSeg;
    logic [WORD_LENGTH-1:0]           lkOfs;
    logic                             lkValid;
    logic                             lkHit;
    logic [WORD_LENGTH-1:0]           lkAdr;
    logic [ACC_WIDTH-1:0]             lkAcc;
    tlbCmdT                           cmd;
    logic [WORD_LENGTH-1:0]           cmdSeg;
    logic [WORD_LENGTH-1:0]           cmdOfs;
    logic [WORD_LENGTH-PAGE_BITS-1:0] cmdPpn;
    logic [ACC_WIDTH-1:0]             cmdAcc;
    logic                             cmdDone;
    logic                             cmdHit;

    modport master (
        output lkReq, lkSeg, lkOfs, cmd, cmdSeg, cmdOfs, cmdPpn, cmdAcc,
        input  lkValid, lkHit, lkAdr, lkAcc, cmdDone, cmdHit
    );

    modport slave (
        input  lkReq, lkSeg, lkOfs, cmd, cmdSeg, cmdOfs, cmdPpn, cmdAcc,
        output lkValid, lkHit, lkAdr, lkAcc, cmdDone, cmdHit
    );
endinterface

// File: rtl/tlb_fa_unit_entry_cam.sv
// One TLB entry: tag/data storage plus two tag comparators, one for the
// lookup port and one for the command port (insert/purge search).
module tlb_entry_cam
    import tlb_fa_unit_pkg::*;
#(
    parameter int VPN_W     = 20,
    parameter int ACC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wrEn,
    input  logic                   clrEn,
    input  logic [WORD_LENGTH-1:0] cmdSeg,
    input  logic [VPN_W-1:0]       cmdVpn,
    input  logic [VPN_W-1:0]       wrPpn,
    input  logic [ACC_WIDTH-1:0]   wrAcc,
    input  logic [WORD_LENGTH-1:0] lkSeg,
    input  logic [VPN_W-1:0]       lkVpn,
    output logic                   lkMatch,
    output logic                   cmdMatch,
    output logic                   valid,
    output logic [VPN_W-1:0]       ppn,
    output logic [ACC_WIDTH-1:0]   acc
);
    logic [WORD_LENGTH-1:0] seg;
    logic [VPN_W-1:0]       vpn;

    // Entry storage: a write installs a full entry, a clear only drops valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            seg   <= '0;
            vpn   <= '0;
            ppn   <= '0;
            acc   <= '0;
        end else if (wrEn) begin
            valid <= 1'b1;
            seg   <= cmdSeg;
            vpn   <= cmdVpn;
            ppn   <= wrPpn;
            acc   <= wrAcc;
        end else if (clrEn) begin
            valid <= 1'b0;
        end
    end

    assign lkMatch  = valid && (seg == lkSeg)  && (vpn == lkVpn);
    assign cmdMatch = valid && (seg == cmdSeg) && (vpn == cmdVpn);

endmodule

// File: rtl/tlb_fa_unit.sv
// Fully associative TLB: parallel lookup with one-cycle registered result,
// command port for insert / purge / purge-all with first-invalid-then-
// round-robin replacement.
module tlb_fa_unit
    import tlb_fa_unit_pkg::*;
#(
    parameter int T_ENTRIES = 16,
    parameter int PAGE_BITS = TLB_PAGE_BITS_DEF,
    parameter int ACC_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    tlb_fa_unit_if.slave bus
);
    localparam int VPN_W = WORD_LENGTH - PAGE_BITS;
    localparam int IDX_W = (T_ENTRIES > 1) ? $clog2(T_ENTRIES) : 1;

    logic [T_ENTRIES-1:0] lkMatchVec;
    logic [T_ENTRIES-1:0] cmdMatchVec;
    logic [T_ENTRIES-1:0] validVec;
    logic [T_ENTRIES-1:0] wrVec;
    logic [T_ENTRIES-1:0] clrVec;
    logic [VPN_W-1:0]     ppnArr [T_ENTRIES];
    logic [ACC_WIDTH-1:0] accArr [T_ENTRIES];

    logic [VPN_W-1:0]     lkVpn;
    logic [VPN_W-1:0]     cmdVpn;
    logic [VPN_W-1:0]     lkPpnSel;
    logic [ACC_WIDTH-1:0] lkAccSel;
    logic                 lkAny;
    logic                 cmdAny;
    logic                 full;
    logic [IDX_W-1:0]     firstInv;
    logic [IDX_W-1:0]     rrPtr;
    logic                 isInsert;
    logic                 isPurge;
    logic                 isPurgeAll;
    logic                 unusedCmdOfs;

    assign lkVpn        = bus.lkOfs[WORD_LENGTH-1:PAGE_BITS];
    assign cmdVpn       = bus.cmdOfs[WORD_LENGTH-1:PAGE_BITS];
    assign unusedCmdOfs = ^bus.cmdOfs[PAGE_BITS-1:0];
    assign isInsert     = (bus.cmd == TLB_CMD_INSERT);
    assign isPurge      = (bus.cmd == TLB_CMD_PURGE);
    assign isPurgeAll   = (bus.cmd == TLB_CMD_PURGE_ALL);
    assign lkAny        = |lkMatchVec;
    assign cmdAny       = |cmdMatchVec;
    assign full         = &validVec;

    for (genvar i = 0; i < T_ENTRIES; i++) begin : gEntry
        tlb_entry_cam #(
            .VPN_W    (VPN_W),
            .ACC_WIDTH(ACC_WIDTH)
        ) uCam (
            .clk     (clk),
            .rst     (rst),
            .wrEn    (wrVec[i]),
            .clrEn   (clrVec[i]),
            .cmdSeg  (bus.cmdSeg),
            .cmdVpn  (cmdVpn),
            .wrPpn   (bus.cmdPpn),
            .wrAcc   (bus.cmdAcc),
            .lkSeg   (bus.lkSeg),
            .lkVpn   (lkVpn),
            .lkMatch (lkMatchVec[i]),
            .cmdMatch(cmdMatchVec[i]),
            .valid   (validVec[i]),
            .ppn     (ppnArr[i]),
            .acc     (accArr[i])
        );
    end

    // Lookup data mux: at most one entry matches, so an OR-reduction selects it.
    always_comb begin
        lkPpnSel = '0;
        lkAccSel = '0;
        for (int i = 0; i < T_ENTRIES; i++) begin
            if (lkMatchVec[i]) begin
                lkPpnSel = lkPpnSel | ppnArr[i];
                lkAccSel = lkAccSel | accArr[i];
            end
        end
    end

    // Priority encoder for the lowest-index invalid entry.
    always_comb begin
        firstInv = '0;
        for (int i = T_ENTRIES - 1; i >= 0; i--) begin
            if (!validVec[i]) begin
                firstInv = IDX_W'(i);
            end
        end
    end

    // Per-entry write/clear strobes: overwrite match, else first invalid, else victim.
    always_comb begin
        wrVec  = '0;
        clrVec = '0;
        if (isInsert) begin
            if (cmdAny) begin
                wrVec = cmdMatchVec;
            end else if (!full) begin
                wrVec[firstInv] = 1'b1;
            end else begin
                wrVec[rrPtr] = 1'b1;
            end
        end else if (isPurge) begin
            clrVec = cmdMatchVec;
        end else if (isPurgeAll) begin
            clrVec = '1;
        end
    end

    // Round-robin victim pointer advances only when a full TLB takes a new tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr <= '0;
        end else if (isPurgeAll) begin
            rrPtr <= '0;
        end else if (isInsert && !cmdAny && full) begin
            rrPtr <= rrPtr + 1'b1;
        end
    end

    // Registered lookup result and command acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.lkValid <= 1'b0;
            bus.lkHit   <= 1'b0;
            bus.lkAdr   <= '0;
            bus.lkAcc   <= '0;
            bus.cmdDone <= 1'b0;
            bus.cmdHit  <= 1'b0;
        end else begin
            bus.lkValid <= bus.lkReq;
            bus.lkHit   <= bus.lkReq && lkAny;
            bus.lkAdr   <= (bus.lkReq && lkAny) ? {lkPpnSel, bus.lkOfs[PAGE_BITS-1:0]} : '0;
            bus.lkAcc   <= (bus.lkReq && lkAny) ? lkAccSel : '0;
            bus.cmdDone <= (bus.cmd != TLB_CMD_NONE);
            bus.cmdHit  <= (isInsert || isPurge) && cmdAny;
        end
    end

endmodule
